dpram_fifo_ctrl: RTL and testbench

// - Ring-buffer FIFO controller sitting directly upstream of the simple dual-port RAM (Memory) and driving it.
// - Port 1 of the RAM is used write-only for pushes; port 2 is used read-only for prefetch.
// - The controller hides the RAM's 1-cycle registered read behind a 2-entry output buffer.
// - Presents valid/ready stream interfaces on both sides; total capacity is DEPTH+2 words.

---
 rtl/dpram_fifo_ctrl_if.sv | 23 ++
 rtl/dpram_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// Stream interface for dpram_fifo_ctrl: the push side (in_*) and the pop side
// (out_*) of the FIFO, both using valid/ready handshakes.
// master = producer/consumer environment, slave = the FIFO controller.
interface dpram_fifo_ctrl_if #(
    parameter int DATA_W = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Ring-buffer FIFO controller driving a simple dual-port RAM.
// Port A of the RAM is written on every accepted push; port B is read to
// prefetch words into a 2-entry output buffer that hides the RAM's registered
// read. Total capacity is DEPTH RAM words plus 2 buffered words.
// Optional macro DPRAM_FIFO_CTRL_LEVEL_EN adds the registered `level` and
// `almost_full` outputs.
module dpram_fifo_ctrl #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    dpram_fifo_ctrl_if.slave  strm,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_W+1:0] level,
    output logic              almost_full
`endif
);

    localparam int CW = ADDR_W + 1;   // mem_count must reach DEPTH itself

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     mem_count_q, mem_count_d;
    logic [1:0]        buf_count_q, buf_count_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic [DATA_W-1:0] obuf_q [2];
    logic [DATA_W-1:0] obuf_d [2];

    logic              push;
    logic              pop;
    logic              rd_issue;
    logic [1:0]        kept;          // buffer entries surviving this cycle's pop

    // Handshake outputs come from registers only, never from the other side's inputs.
    assign strm.in_ready  = (mem_count_q < CW'(DEPTH));
    assign strm.out_valid = (buf_count_q != 2'd0);
    assign strm.out_data  = obuf_q[0];

    assign push = strm.in_valid && strm.in_ready;
    assign pop  = strm.out_valid && strm.out_ready;
    assign kept = buf_count_q - {1'b0, pop};

    // Prefetch only when the words already held or in flight leave room in the buffer.
    // The read only targets committed words, so it never hits the slot written this cycle.
    assign rd_issue = (mem_count_q != '0) &&
                      (({1'b0, kept} + {2'b00, rd_inflight_q}) < 3'd2);

    assign ram_addr_a = wr_ptr_q;
    assign ram_data_a = strm.in_data;
    assign ram_we_a   = push;
    assign ram_addr_b = rd_ptr_q;
    assign ram_we_b   = 1'b0;

    // Next-state logic for pointers, counters and the output buffer.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block leaves a latch.
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        obuf_d[0]     = obuf_q[0];
        obuf_d[1]     = obuf_q[1];
        rd_inflight_d = rd_issue;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);   // natural wrap since DEPTH = 2**ADDR_W
        end
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        mem_count_d = mem_count_q + CW'(push) - CW'(rd_issue);

        // Pop shifts only when a second word exists; popping the last word
        // leaves the head register alone so out_data holds its last value.
        if (pop && buf_count_q == 2'd2) begin
            obuf_d[0] = obuf_q[1];
        end
        // The RAM word issued last cycle lands behind whatever survives the pop.
        if (rd_inflight_q) begin
            if (kept == 2'd0) begin
                obuf_d[0] = ram_q_b;
            end else begin
                obuf_d[1] = ram_q_b;
            end
        end

        buf_count_d = kept + {1'b0, rd_inflight_q};
    end

    // State registers; reset discards everything in flight (RAM contents untouched).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_count_q   <= '0;
            buf_count_q   <= '0;
            rd_inflight_q <= 1'b0;
            // NOTE: the 2-entry buffer is reset (unlike the RAM) because its head is out_data, which must read 0 after reset.
            obuf_q[0]     <= '0;
            obuf_q[1]     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_count_q   <= mem_count_d;
            buf_count_q   <= buf_count_d;
            rd_inflight_q <= rd_inflight_d;
            obuf_q[0]     <= obuf_d[0];
            obuf_q[1]     <= obuf_d[1];
        end
    end

`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
    logic [ADDR_W+1:0] level_q;
    logic              almost_full_q;

    // Occupancy flags registered from next-state values so they track the live counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= (ADDR_W+2)'(mem_count_d) + (ADDR_W+2)'(buf_count_d)
                             + (ADDR_W+2)'(rd_inflight_d);
            almost_full_q <= (mem_count_d >= CW'(DEPTH - 4));
        end
    end

    assign level       = level_q;
    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl: a behavioural RAM with registered
// read, and a word queue as the reference FIFO.
module tb_dpram_fifo_ctrl;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int CAP    = DEPTH + 2;

    logic clk;
    logic rst;

    dpram_fifo_ctrl_if #(.DATA_W(DATA_W)) f ();

    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic              ram_we_b;
    logic [DATA_W-1:0] ram_q_b;
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
    logic [ADDR_W+1:0] level;
    logic              almost_full;
`endif

    dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .strm       (f.slave),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_b (ram_addr_b),
        .ram_we_b   (ram_we_b),
        .ram_q_b    (ram_q_b)
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    // Simple dual-port RAM: write port A, registered read port B.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
        ram_q_b <= ram[ram_addr_b];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] model [$];   // words pushed and not yet popped
    int                wr_cnt = 0;  // pushes since reset (write address source)

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, update the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r,
                        output logic pushed, output logic popped,
                        output logic [DATA_W-1:0] od);
        f.in_valid  = v;
        f.in_data   = d;
        f.out_ready = r;
        @(negedge clk);
        pushed = v && f.in_ready;
        popped = f.out_valid && r;
        od     = f.out_data;
        if (model.size() < DEPTH) check("in_ready_room", f.in_ready, 1);
        if (model.size() >= CAP) check("in_ready_full", f.in_ready, 0);
        if (model.size() == 0) check("out_valid_empty", f.out_valid, 0);
        check("ram_we_a", ram_we_a, pushed);
        check("ram_we_b", ram_we_b, 0);
        if (pushed) begin
            check("ram_addr_a", ram_addr_a, wr_cnt % DEPTH);
            check("ram_data_a", ram_data_a, d);
        end
        if (popped && model.size() != 0) begin
            check("out_data", f.out_data, model[0]);
            void'(model.pop_front());
        end
        if (pushed) begin
            model.push_back(d);
            wr_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        logic p, q;
        logic [DATA_W-1:0] od;
        for (int i = 0; i < 300 && model.size() != 0; i++) step(1'b0, '0, 1'b1, p, q, od);
        check(tag, model.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic p, q;
        logic [DATA_W-1:0] od;
        int acc, sent, pops, first_pop, last_pop, cyc;

        rst = 1'b1;
        f.in_valid = 1'b0; f.in_data = '0; f.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_data", f.out_data, 0);
        check("rst_out_valid", f.out_valid, 0);
        check("rst_in_ready", f.in_ready, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b0, p, q, od);
            check("idle_in_ready", f.in_ready, 1);
            check("idle_out_valid", f.out_valid, 0);
        end

        // Single word latency: visible three cycles after the accepting edge.
        step(1'b1, 14'h1234, 1'b1, p, q, od);
        check("lat_push", p, 1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, '0, 1'b1, p, q, od);
            check("lat_out_valid", q, (k == 3) ? 1 : 0);
            if (k == 3) check("lat_out_data", od, 14'h1234);
        end

        // Fill with out_ready low: exactly DEPTH+2 words accepted.
        acc = 0;
        for (int i = 0; i < CAP + 6; i++) begin
            step(1'b1, DATA_W'(i), 1'b0, p, q, od);
            if (p) acc++;
        end
        check("fill_accepts", acc, CAP);
        check("fill_in_ready", f.in_ready, 0);
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
        check("fill_level", level, CAP);
        check("fill_almost_full", almost_full, 1);
`endif
        step(1'b0, '0, 1'b1, p, q, od);
        check("fill_first_pop", od, 0);
        check("refill_in_ready", f.in_ready, 1);
        drain("fill_drain");
`ifdef DPRAM_FIFO_CTRL_LEVEL_EN
        check("drain_level", level, 0);
`endif

        // Streaming: 200 words back to back, no gaps once the first arrives.
        sent = 0; pops = 0; first_pop = -1; last_pop = -1;
        for (cyc = 0; cyc < 600 && pops < 200; cyc++) begin
            step(sent < 200, DATA_W'(sent + 100), 1'b1, p, q, od);
            if (p) sent++;
            if (q) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
        check("stream_pops", pops, 200);
        check("stream_latency", first_pop, 3);
        check("stream_gaps", (last_pop - first_pop + 1) - pops, 0);

        // Random traffic at 50% density on both sides.
        sent = 0;
        for (cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
            step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)), p, q, od);
            if (p) sent++;
        end
        check("rand_sent", sent, 1000);
        drain("rand_drain");

        // Reset in the middle of a stream with 20 words queued.
        for (int i = 0; i < 20; i++) step(1'b1, DATA_W'(i + 500), 1'b0, p, q, od);
        f.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", f.out_valid, 0);
        check("midrst_in_ready", f.in_ready, 1);
        check("midrst_ram_we_a", ram_we_a, 0);
        model.delete();
        wr_cnt = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 14'h0ABC, 1'b0, p, q, od);
        acc = 0;
        for (int i = 0; i < 10 && acc == 0; i++) begin
            step(1'b0, '0, 1'b1, p, q, od);
            if (q) begin
                acc = 1;
                check("midrst_first_word", od, 14'h0ABC);
            end
        end
        check("midrst_popped", acc, 1);
        step(1'b0, '0, 1'b1, p, q, od);
        check("midrst_empty_after", q, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
